// File: rtl/pcm_mm_arbiter.sv
// pcm_mm_arbiter: lets four CPU ports share one single-port PCM memory over an
// Avalon-MM master port. New requests are detected by comparing each port
// against the snapshot taken at its last grant, and pending ports are granted
// round-robin.
// Optional build macro: PCM_MM_SNOOP_EN. When defined, a completed in-range
// write re-queues every other CPU whose last access was a read of that address.
module pcm_mm_arbiter #(
    parameter int MEM_AW       = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              cpu0_write,
    input  logic [19:0]       cpu0_addr,
    input  logic [15:0]       cpu0_data_in,
    output logic              cpu0_ready,
    output logic [15:0]       cpu0_data_out,
    input  logic              cpu1_write,
    input  logic [19:0]       cpu1_addr,
    input  logic [15:0]       cpu1_data_in,
    output logic              cpu1_ready,
    output logic [15:0]       cpu1_data_out,
    input  logic              cpu2_write,
    input  logic [19:0]       cpu2_addr,
    input  logic [15:0]       cpu2_data_in,
    output logic              cpu2_ready,
    output logic [15:0]       cpu2_data_out,
    input  logic              cpu3_write,
    input  logic [19:0]       cpu3_addr,
    input  logic [15:0]       cpu3_data_in,
    output logic              cpu3_ready,
    output logic [15:0]       cpu3_data_out,
    output logic [MEM_AW-1:0] pcm_mem_mm_address,
    output logic              pcm_mem_mm_chipselect,
    output logic              pcm_mem_mm_clken,
    output logic              pcm_mem_mm_write,
    input  logic [15:0]       pcm_mem_mm_readdata,
    output logic [15:0]       pcm_mem_mm_writedata,
    output logic [1:0]        pcm_mem_mm_byteenable
);

    // state  | meaning
    // S_IDLE | no transfer; grant the next pending CPU from the pointer
    // S_ISSUE| drive address/strobes for one cycle
    // S_WAIT | read in flight, count down the memory read latency
    // S_DONE | capture read data, retire or re-queue the granted CPU
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    state_t            state;
    logic [3:0][19:0]  req_addr;
    logic [3:0][15:0]  req_data;
    logic [3:0]        req_write;
    logic [3:0][19:0]  last_addr;
    logic [3:0][15:0]  last_data;
    logic [3:0]        last_write;
    logic [3:0][15:0]  dout;
    logic [3:0]        pending;
    logic [3:0]        pend_nxt;
    logic [3:0]        ready_q;
    logic [3:0]        new_req;
    logic [1:0]        ptr;
    logic [1:0]        gnt;
    logic [1:0]        pick_idx;
    logic              pick_valid;
    logic [1:0]        lat_cnt;
    logic              redo;
    logic              cur_oor;

    function automatic logic addr_oor(input logic [19:0] a);
        return (a >> MEM_AW) != 20'd0;
    endfunction

    assign req_addr  = {cpu3_addr, cpu2_addr, cpu1_addr, cpu0_addr};
    assign req_data  = {cpu3_data_in, cpu2_data_in, cpu1_data_in, cpu0_data_in};
    assign req_write = {cpu3_write, cpu2_write, cpu1_write, cpu0_write};

    assign cpu0_ready    = ready_q[0];
    assign cpu1_ready    = ready_q[1];
    assign cpu2_ready    = ready_q[2];
    assign cpu3_ready    = ready_q[3];
    assign cpu0_data_out = dout[0];
    assign cpu1_data_out = dout[1];
    assign cpu2_data_out = dout[2];
    assign cpu3_data_out = dout[3];

    assign pcm_mem_mm_byteenable = 2'b11;
    assign pcm_mem_mm_clken      = 1'b1;

    assign cur_oor = addr_oor(last_addr[gnt]);

    // A port has a new request whenever it differs from its last granted snapshot.
    always_comb begin
        new_req = '0;
        for (int i = 0; i < 4; i++) begin
            new_req[i] = (req_addr[i] != last_addr[i]) ||
                         (req_write[i] != last_write[i]) ||
                         (req_write[i] && (req_data[i] != last_data[i]));
        end
    end

    // Round-robin search: first pending port starting at the pointer.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            if (!pick_valid && pending[ptr + 2'(i)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr + 2'(i);
            end
        end
    end

    // Next pending bits: set by detection or init, retired by the DONE state.
    always_comb begin
        pend_nxt = pending | new_req;
        if (init) begin
            pend_nxt = 4'hF;
        end
        if (state == S_DONE) begin
            // The granted port stays pending if it changed or init hit mid-transfer.
            pend_nxt[gnt] = new_req[gnt] | init | redo;
`ifdef PCM_MM_SNOOP_EN
            if (last_write[gnt] && !cur_oor) begin
                for (int i = 0; i < 4; i++) begin
                    if ((2'(i) != gnt) && !last_write[i] && (last_addr[i] == last_addr[gnt])) begin
                        pend_nxt[i] = 1'b1;
                    end
                end
            end
`endif
        end
    end

    // Arbiter FSM, snapshots, ready flags and registered memory-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= S_IDLE;
            pending               <= '0;
            ready_q               <= '0;
            last_addr             <= '0;
            last_data             <= '0;
            last_write            <= '0;
            dout                  <= '0;
            ptr                   <= '0;
            gnt                   <= '0;
            lat_cnt               <= '0;
            redo                  <= 1'b0;
            pcm_mem_mm_address    <= '0;
            pcm_mem_mm_chipselect <= 1'b0;
            pcm_mem_mm_write      <= 1'b0;
            pcm_mem_mm_writedata  <= '0;
        end else begin
            pending <= pend_nxt;
            ready_q <= ~pend_nxt;
            if (init) begin
                redo <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt                  <= pick_idx;
                        ptr                  <= pick_idx + 2'd1;
                        last_addr[pick_idx]  <= req_addr[pick_idx];
                        last_data[pick_idx]  <= req_data[pick_idx];
                        last_write[pick_idx] <= req_write[pick_idx];
                        redo                 <= init;
                        // Out-of-range requests never touch the memory.
                        state <= addr_oor(req_addr[pick_idx]) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pcm_mem_mm_address    <= last_addr[gnt][MEM_AW-1:0];
                    pcm_mem_mm_chipselect <= 1'b1;
                    if (last_write[gnt]) begin
                        pcm_mem_mm_write     <= 1'b1;
                        pcm_mem_mm_writedata <= last_data[gnt];
                        state                <= S_DONE;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    pcm_mem_mm_chipselect <= 1'b0;
                    if (lat_cnt == 2'd0) begin
                        state <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    pcm_mem_mm_chipselect <= 1'b0;
                    pcm_mem_mm_write      <= 1'b0;
                    if (!last_write[gnt]) begin
                        dout[gnt] <= cur_oor ? 16'h0000 : pcm_mem_mm_readdata;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_mm_arbiter.sv
`timescale 1ns/1ps
// Testbench for pcm_mm_arbiter: directed scenarios plus randomized traffic,
// with a scoreboard of expected per-CPU results and expected bus transfers.
module tb_pcm_mm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        wr_i   [4];
    logic [19:0] addr_i [4];
    logic [15:0] din_i  [4];
    logic        rdy    [4];
    logic [15:0] dout   [4];
    logic [10:0] maddr;
    logic        cs;
    logic        clken;
    logic        mwr;
    logic [15:0] rdata = '0;
    logic [15:0] wdata;
    logic [1:0]  be;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        wr;
        logic [10:0] addr;
        logic [15:0] data;
    } bus_t;

    logic [15:0] mem     [2048];
    logic [15:0] ref_mem [2048];
    logic        m_wr    [4];
    logic [19:0] m_addr  [4];
    logic [15:0] m_data  [4];
    logic [15:0] exp_dout[4];
    logic [15:0] res_q   [4][$];
    bus_t        bus_q   [4][$];
    bit          bus_mon_en = 1'b0;
    bit          rdy_mon_en = 1'b0;
    bit          prev_rdy [4];
    int          bn;
    bus_t        bexp;

    pcm_mm_arbiter dut (
        .clk                   (clk),
        .reset                 (reset),
        .init                  (init),
        .cpu0_write            (wr_i[0]),
        .cpu0_addr             (addr_i[0]),
        .cpu0_data_in          (din_i[0]),
        .cpu0_ready            (rdy[0]),
        .cpu0_data_out         (dout[0]),
        .cpu1_write            (wr_i[1]),
        .cpu1_addr             (addr_i[1]),
        .cpu1_data_in          (din_i[1]),
        .cpu1_ready            (rdy[1]),
        .cpu1_data_out         (dout[1]),
        .cpu2_write            (wr_i[2]),
        .cpu2_addr             (addr_i[2]),
        .cpu2_data_in          (din_i[2]),
        .cpu2_ready            (rdy[2]),
        .cpu2_data_out         (dout[2]),
        .cpu3_write            (wr_i[3]),
        .cpu3_addr             (addr_i[3]),
        .cpu3_data_in          (din_i[3]),
        .cpu3_ready            (rdy[3]),
        .cpu3_data_out         (dout[3]),
        .pcm_mem_mm_address    (maddr),
        .pcm_mem_mm_chipselect (cs),
        .pcm_mem_mm_clken      (clken),
        .pcm_mem_mm_write      (mwr),
        .pcm_mem_mm_readdata   (rdata),
        .pcm_mem_mm_writedata  (wdata),
        .pcm_mem_mm_byteenable (be)
    );

    always #5 clk = ~clk;

    // Memory with one cycle of read latency.
    always @(posedge clk) begin
        if (cs) begin
            if (mwr) mem[maddr] <= wdata;
            else     rdata <= mem[maddr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: executes a CPU's request in isolation against ref_mem.
    task automatic model_exec(input int n);
        bit   oor;
        bus_t b;
        oor = (m_addr[n] >> 11) != 20'd0;
        if (m_wr[n]) begin
            if (!oor) ref_mem[m_addr[n][10:0]] = m_data[n];
        end else begin
            exp_dout[n] = oor ? 16'h0000 : ref_mem[m_addr[n][10:0]];
        end
        res_q[n].push_back(exp_dout[n]);
        if (bus_mon_en && !oor) begin
            b.wr   = m_wr[n];
            b.addr = m_addr[n][10:0];
            b.data = m_wr[n] ? m_data[n] : 16'h0000;
            bus_q[n].push_back(b);
        end
    endtask

    task automatic issue(input int n, input logic w, input logic [19:0] a, input logic [15:0] d);
        wr_i[n] = w; addr_i[n] = a; din_i[n] = d;
        m_wr[n] = w; m_addr[n] = a; m_data[n] = d;
        model_exec(n);
    endtask

    function automatic bit all_rdy();
        return rdy[0] & rdy[1] & rdy[2] & rdy[3];
    endfunction

    function automatic int q_total();
        return res_q[0].size() + res_q[1].size() + res_q[2].size() + res_q[3].size();
    endfunction

    task automatic drain(input string name);
        int c = 0;
        while (c < 300 && q_total() != 0) begin
            @(posedge clk);
            c++;
        end
        check({name, "_drain_left"}, q_total(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_address"}, 32'(maddr), 0);
        check({tag, "_chipselect"}, 32'(cs), 0);
        check({tag, "_write"}, 32'(mwr), 0);
        check({tag, "_writedata"}, 32'(wdata), 0);
        check({tag, "_byteenable"}, 32'(be), 3);
        check({tag, "_clken"}, 32'(clken), 1);
        for (int n = 0; n < 4; n++) begin
            check($sformatf("%s_ready%0d", tag, n), 32'(rdy[n]), 0);
            check($sformatf("%s_dout%0d", tag, n), 32'(dout[n]), 0);
        end
    endtask

    // Result monitor: each rising ready retires the oldest expected result.
    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rdy_mon_en && rdy[n] && !prev_rdy[n]) begin
                check($sformatf("cpu%0d_ready_expected", n), 32'(res_q[n].size() != 0), 1);
                if (res_q[n].size() != 0)
                    check($sformatf("cpu%0d_data_out", n), 32'(dout[n]), 32'(res_q[n].pop_front()));
            end
            prev_rdy[n] = rdy[n];
        end
    end

    // Bus monitor for random traffic: the address region identifies the CPU.
    always @(negedge clk) begin
        if (bus_mon_en && cs) begin
            bn = int'(maddr[7:6]);
            check("bus_region", 32'(maddr[10:8]), 2);
            check($sformatf("bus_cpu%0d_expected", bn), 32'(bus_q[bn].size() != 0), 1);
            if (bus_q[bn].size() != 0) begin
                bexp = bus_q[bn].pop_front();
                check($sformatf("bus_cpu%0d_addr", bn), 32'(maddr), 32'(bexp.addr));
                check($sformatf("bus_cpu%0d_write", bn), 32'(mwr), 32'(bexp.wr));
                if (bexp.wr) check($sformatf("bus_cpu%0d_wdata", bn), 32'(wdata), 32'(bexp.data));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          rise [4];
        int          cs_cnt;
        logic [10:0] seen [$];
        int          n;
        logic        w;
        logic [19:0] a;
        logic [15:0] d;

        reset = 1'b0;
        init  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_i[i] = 1'b0; addr_i[i] = '0; din_i[i] = '0;
            m_wr[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; exp_dout[i] = '0;
        end
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'($urandom);
        end
        mem[0] = 16'h0000;
        mem[11'h066] = 16'h9999;
        for (int i = 0; i < 4; i++) mem[11'h101 + i] = 16'hA101 + 16'(i);
        for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rdy_mon_en = 1'b1;
        for (int i = 0; i < 4; i++) check($sformatf("post_reset_ready%0d", i), 32'(rdy[i]), 1);

        // init: re-reads address 0 for every CPU
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        for (int i = 0; i < 4; i++) model_exec(i);
        check("init_ready_cleared", 32'(all_rdy()), 0);
        cyc = 0;
        while (cyc < 20 && !all_rdy()) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("init_all_ready_20", 32'(all_rdy()), 1);
        drain("init");

        // All four change in the same cycle: round-robin order 0,1,2,3
        for (int i = 0; i < 4; i++) issue(i, 1'b0, 20'h101 + 20'(i), 16'h0);
        for (int i = 0; i < 4; i++) rise[i] = -1;
        seen.delete();
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cs) seen.push_back(maddr);
            for (int i = 0; i < 4; i++) if (rdy[i] && rise[i] < 0) rise[i] = cyc;
        end
        check("rr_strobe_count", 32'(seen.size()), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check($sformatf("rr_addr%0d", i), 32'(seen[i]), 32'h101 + 32'(i));
        check("rr_ready0_seen", 32'(rise[0] > 0), 1);
        for (int i = 1; i < 4; i++)
            check($sformatf("rr_ready_order%0d", i), 32'(rise[i] > rise[i-1]), 1);
        drain("rr");

        // Single read latency: address at 3 cycles, ready/data at 5
        issue(0, 1'b0, 20'h00066, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("lat_address", 32'(maddr), 32'h066);
        check("lat_chipselect", 32'(cs), 1);
        repeat (2) @(posedge clk);
        #1;
        check("lat_ready0", 32'(rdy[0]), 1);
        check("lat_dout0", 32'(dout[0]), 32'h9999);
        repeat (3) @(posedge clk);
        #1;
        check("addr_hold", 32'(maddr), 32'h066);
        drain("lat");

        // Single write strobe
        issue(1, 1'b1, 20'h00010, 16'hABCD);
        repeat (3) @(posedge clk);
        #1;
        check("wr_chipselect", 32'(cs), 1);
        check("wr_write", 32'(mwr), 1);
        check("wr_address", 32'(maddr), 32'h010);
        check("wr_writedata", 32'(wdata), 32'hABCD);
        @(posedge clk);
        #1;
        check("wr_cs_one_cycle", 32'(cs), 0);
        check("wr_write_one_cycle", 32'(mwr), 0);
        check("wr_ready1", 32'(rdy[1]), 1);
        for (int i = 0; i < 4; i++)
            if (i != 1) check($sformatf("wr_other_ready%0d", i), 32'(rdy[i]), 1);
        check("wr_other_dout0", 32'(dout[0]), 32'h9999);
        drain("wr");

        // Out-of-range read: no strobe, data 0
        issue(2, 1'b0, 20'h00800, 16'h0);
        cs_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (cs) cs_cnt++;
        end
        check("oor_no_strobe", 32'(cs_cnt), 0);
        check("oor_ready2", 32'(rdy[2]), 1);
        check("oor_dout2", 32'(dout[2]), 0);
        drain("oor");

        // Randomized traffic, each CPU in its own address region
        bus_mon_en = 1'b1;
        for (int it = 0; it < 300; it++) begin
            n = int'($urandom_range(0, 3));
            if (rdy[n] && res_q[n].size() == 0) begin
                w = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0)
                    a = {9'($urandom_range(1, 511)), 11'($urandom)};
                else
                    a = 20'h200 + 20'(n * 64) + 20'($urandom_range(0, 63));
                d = 16'($urandom);
                if (!w && !m_wr[n] && a == m_addr[n]) a = a ^ 20'h1;
                if (w && m_wr[n] && a == m_addr[n] && d == m_data[n]) d = d ^ 16'h1;
                issue(n, w, a, d);
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        drain("rand");
        for (int i = 0; i < 4; i++) check($sformatf("rand_bus_left%0d", i), 32'(bus_q[i].size()), 0);
        bus_mon_en = 1'b0;

        // Reset in the middle of a read
        issue(3, 1'b0, 20'h00123, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("midrd_chipselect", 32'(cs), 1);
        rdy_mon_en = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values("midrd");
        for (int i = 0; i < 4; i++) begin
            res_q[i].delete();
            bus_q[i].delete();
            wr_i[i] = 1'b0; addr_i[i] = '0; din_i[i] = '0;
            m_wr[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; exp_dout[i] = '0;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rdy_mon_en = 1'b1;
        check("midrd_after_ready", 32'(all_rdy()), 1);
        issue(0, 1'b0, 20'h00066, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("midrd_idle_address", 32'(maddr), 32'h066);
        check("midrd_idle_chipselect", 32'(cs), 1);
        drain("midrd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcm_mm_arbiter.md
Name: pcm_mm_arbiter

Overview:
- Arbiter and memory-mapped master that lets four CPU ports share one single-port on-chip PCM memory through an Avalon-MM slave interface.
- Detects a new request on each CPU port, grants ports round-robin, and performs the read or write on the memory.
- Returns read data per CPU with a level ready flag.
- Sits between the CPU cores and the Avalon on-chip RAM in the SoC.

Parameters:
- MEM_AW, 11, memory word-address width; low MEM_AW bits of the CPU address select the word.
- READ_LATENCY, 1, clocks from an issued read to valid pcm_mem_mm_readdata (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  synchronous one-cycle pulse: mark every CPU pending and clear ready.
- cpuN_write  in  1  (N=0..3) 1 = write request, 0 = read.
- cpuN_addr  in  20  (N=0..3) word address.
- cpuN_data_in  in  16  (N=0..3) write data.
- cpuN_ready  out  1  (N=0..3) 1 = last request of CPU N complete, no request pending.
- cpuN_data_out  out  16  (N=0..3) read data of CPU N's last read.
- pcm_mem_mm_address  out  MEM_AW  memory word address.
- pcm_mem_mm_chipselect  out  1  access strobe.
- pcm_mem_mm_clken  out  1  memory clock enable.
- pcm_mem_mm_write  out  1  write strobe.
- pcm_mem_mm_readdata  in  16  memory read data.
- pcm_mem_mm_writedata  out  16  memory write data.
- pcm_mem_mm_byteenable  out  2  byte enables.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - all outputs 0, except pcm_mem_mm_byteenable=2'b11 and pcm_mem_mm_clken=1;
  - pending bits 0, snapshot registers 0, round-robin pointer 0, FSM in IDLE.
- Per-CPU snapshot registers: last_addr, last_write, last_data, each updated when that CPU is granted.
- Request detection, per CPU, every cycle:
  - new request when cpuN_addr != last_addr, or cpuN_write != last_write, or (cpuN_write=1 and cpuN_data_in != last_data);
  - the pending bit sets on the next edge;
  - cpuN_ready = ~pending, registered, clears the cycle after detection.
- init: sets all four pending bits and clears all ready flags. If a transfer is in progress, it completes normally and its CPU stays pending.
- FSM states:
  - IDLE: if any pending bit is set, grant the first pending CPU searching from the pointer (pointer = last granted + 1, mod 4). Capture its addr/write/data into the snapshot, go to ISSUE.
  - ISSUE: one cycle.
    - pcm_mem_mm_address = addr[MEM_AW-1:0], chipselect=1.
    - Write: write=1 and writedata=data.
    - Next state: WAIT for a read, DONE for a write.
  - WAIT: chipselect=0; count READ_LATENCY cycles, then DONE.
  - DONE:
    - For a read, cpuN_data_out <= pcm_mem_mm_readdata.
    - Clear pending unless a new request was detected during the transfer; in that case pending stays 1 and it is re-serviced.
    - Return to IDLE.
- pcm_mem_mm_address holds the last issued address while idle; it never returns to 0 on its own.
- Out-of-range address (cpuN_addr[19:MEM_AW] != 0):
  - no memory strobe;
  - read returns 0x0000, write is discarded;
  - completes in DONE on the cycle after grant.
- Worst-case latency, single requester, READ_LATENCY=1: address on bus 3 cycles after the input change; ready 5 cycles after.
- With all four CPUs pending, each is served in round-robin order; none waits more than 4 transfers.
- Simultaneous requests are ordered only by the round-robin pointer.
- cpuN_data_out is stable between that CPU's reads.
- byteenable is always 2'b11; clken is always 1 out of reset.

Optional Feature:
- Macro: PCM_MM_SNOOP_EN.
- When defined: after a completed in-range write, every other CPU whose last_addr equals the written address and whose last access was a read gets its pending bit set (ready drops). That CPU is then re-read, so its data_out reflects the new value.
- When undefined: writes never affect other CPUs' pending bits or data_out.

Test Plan:
- Reset, pulse init with all addresses 0 and readdata=0x0000 -> four reads of address 0; all cpuN_ready=1 within 20 cycles; all data_out=0x0000.
- After init, set cpu0_addr=0x066 and drive readdata=0x9999 -> pcm_mem_mm_address=0x066 within 3 cycles; cpu0_ready=1 and cpu0_data_out=0x9999 within 5 cycles; address holds 0x066 afterwards.
- cpu1_write=1, cpu1_addr=0x010, data_in=0xABCD -> one cycle with chipselect=1, write=1, address 0x010, writedata=0xABCD; cpu1_ready rises; other CPUs unaffected.
- All four CPUs change address in the same cycle -> grants in order 0,1,2,3 (from pointer 0); each ready rises in that order.
- cpu2_addr=0x00800 (out of range) -> no chipselect pulse; cpu2_data_out=0x0000; cpu2_ready=1.
- Assert reset mid-read -> all outputs return to reset values immediately; FSM is in IDLE after release.
